// File: rtl/keypad_pkg.sv
// Shared scan-state encoding, queued event record and elaboration helpers
// for the matrix keypad scanner.
package keypad_pkg;

  localparam int MAX_KEY_W = 6;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    SAMPLE = 2'd1,
    EVAL   = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic [MAX_KEY_W-1:0] code;
    logic                 press;
    logic                 is_repeat;
  } key_event_t;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// First-word fall-through event queue; a push into a full queue is accepted
// only when a pop frees a slot in the same cycle, otherwise it is dropped.
module keypad_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clock_keyboards,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_write;
  logic             do_read;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_read  = pop && !empty;
  assign do_write = push && (!full || do_read);
  assign drop     = push && full && !do_read;
  assign head     = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clock_keyboards or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_read)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: the head is only meaningful while non-empty.
  always_ff @(posedge clock_keyboards) begin
    if (do_write) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, per-key frame debounce, event queue.
// Optional auto-repeat of the last pressed key is built when KEYPAD_REPEAT_EN is defined.
//   state  | meaning
//   SETTLE | column driven, waiting for row lines to settle
//   SAMPLE | latch inverted row lines for the driven column
//   EVAL   | debounce one key per cycle, row = step
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter  int ROWS               = 4,
  parameter  int COLS               = 4,
  parameter  int SETTLE_CYCLES      = 2,
  parameter  int DEBOUNCE_SCANS     = 900,
  parameter  int FIFO_DEPTH         = 8,
  parameter  int REPEAT_DELAY_SCANS = 20000,
  parameter  int REPEAT_RATE_SCANS  = 4000,
  localparam int KEY_W              = $clog2(ROWS*COLS)
) (
  input  logic                 clock_keyboards,
  input  logic                 reset_n,
  input  logic [ROWS-1:0]      keyboard_row_n,
  output logic [COLS-1:0]      keyboard_col_n,
  output logic [ROWS*COLS-1:0] keys,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [KEY_W-1:0]     event_code,
  output logic                 event_press,
  output logic                 event_repeat,
  output logic                 overflow,
  input  logic                 clear_overflow
);

  localparam int NKEYS  = ROWS*COLS;
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int STEP_W = $clog2(SETTLE_CYCLES + ROWS);
  localparam int CNT_W  = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam int EV_W   = $bits(key_event_t);

  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("keypad_scanner: FIFO_DEPTH must be a power of two >= 2");
  end
  if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || KEY_W > MAX_KEY_W) begin : g_bad_matrix
    $error("keypad_scanner: ROWS and COLS must be within 2..8");
  end
  if (SETTLE_CYCLES < 1 || DEBOUNCE_SCANS < 1 ||
      REPEAT_DELAY_SCANS < 1 || REPEAT_RATE_SCANS < 1) begin : g_bad_timing
    $error("keypad_scanner: cycle and scan counts must be >= 1");
  end

  scan_state_t       state;
  scan_state_t       state_nxt;
  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  col_nxt;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] step_nxt;
  logic              active;
  logic              sample_en;
  logic              eval_en;
  logic [ROW_W-1:0]  row;

  // active holds the scan off for the first cycle so column 0 gets a full period.
  always_ff @(posedge clock_keyboards or negedge reset_n) begin
    if (!reset_n) begin
      state  <= SETTLE;
      col    <= '0;
      step   <= STEP_W'(SETTLE_CYCLES-1);
      active <= 1'b0;
    end else begin
      state  <= state_nxt;
      col    <= col_nxt;
      step   <= step_nxt;
      active <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    step_nxt  = step;
    if (active) begin
      case (state)
        SETTLE: begin
          if (step == '0) state_nxt = SAMPLE;
          else            step_nxt  = step - STEP_W'(1);
        end
        SAMPLE: begin
          state_nxt = EVAL;
          step_nxt  = '0;
        end
        EVAL: begin
          if (step == STEP_W'(ROWS-1)) begin
            state_nxt = SETTLE;
            step_nxt  = STEP_W'(SETTLE_CYCLES-1);
            col_nxt   = (col == COL_W'(COLS-1)) ? '0 : col + COL_W'(1);
          end else begin
            step_nxt = step + STEP_W'(1);
          end
        end
        default: begin
          state_nxt = SETTLE;
          step_nxt  = STEP_W'(SETTLE_CYCLES-1);
        end
      endcase
    end
  end

  always_comb begin
    keyboard_col_n = '1;
    sample_en      = 1'b0;
    eval_en        = 1'b0;
    if (active) begin
      keyboard_col_n = ~({{(COLS-1){1'b0}}, 1'b1} << col);
      sample_en      = (state == SAMPLE);
      eval_en        = (state == EVAL);
    end
  end

  assign row = step[ROW_W-1:0];

  logic [ROWS-1:0]  row_sample;
  logic [CNT_W-1:0] cnt [NKEYS];
  logic [KEY_W-1:0] key_idx;
  logic             key_now;
  logic             key_cur;
  logic             cnt_done;
  logic             toggle;

  always_ff @(posedge clock_keyboards or negedge reset_n) begin
    if (!reset_n)       row_sample <= '0;
    else if (sample_en) row_sample <= ~keyboard_row_n;
  end

  assign key_idx  = KEY_W'(int'(row) * COLS + int'(col));
  assign key_now  = row_sample[row];
  assign key_cur  = keys[key_idx];
  assign cnt_done = (cnt[key_idx] == CNT_W'(DEBOUNCE_SCANS-1));
  assign toggle   = eval_en && (key_now != key_cur) && cnt_done;

  // Any sample that agrees with the stable level restarts that key's count.
  always_ff @(posedge clock_keyboards or negedge reset_n) begin
    if (!reset_n) begin
      keys <= '0;
      for (int i = 0; i < NKEYS; i++) cnt[i] <= '0;
    end else if (eval_en) begin
      if (key_now == key_cur) begin
        cnt[key_idx] <= '0;
      end else if (cnt_done) begin
        keys[key_idx] <= key_now;
        cnt[key_idx]  <= '0;
      end else begin
        cnt[key_idx] <= cnt[key_idx] + CNT_W'(1);
      end
    end
  end

  logic       push;
  key_event_t push_ev;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                           REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  logic             rep_active;
  logic [KEY_W-1:0] rep_key;
  logic [REP_W-1:0] rep_cnt;
  logic             frame_tick;
  logic             rep_fire;

  // Frame tick lands in SETTLE, so a repeat push never collides with an EVAL push.
  assign frame_tick = active && (state == SETTLE) && (col == '0) &&
                      (step == STEP_W'(SETTLE_CYCLES-1));
  assign rep_fire   = rep_active && frame_tick && (rep_cnt == '0);

  always_ff @(posedge clock_keyboards or negedge reset_n) begin
    if (!reset_n) begin
      rep_active <= 1'b0;
      rep_key    <= '0;
      rep_cnt    <= '0;
    end else if (toggle && key_now) begin
      rep_active <= 1'b1;
      rep_key    <= key_idx;
      rep_cnt    <= REP_W'(REPEAT_DELAY_SCANS-1);
    end else if (toggle && (key_idx == rep_key)) begin
      rep_active <= 1'b0;
    end else if (rep_active && frame_tick) begin
      rep_cnt <= (rep_cnt == '0) ? REP_W'(REPEAT_RATE_SCANS-1) : rep_cnt - REP_W'(1);
    end
  end

  assign push = toggle || rep_fire;

  always_comb begin
    push_ev = '0;
    if (toggle) begin
      push_ev.code  = MAX_KEY_W'(key_idx);
      push_ev.press = key_now;
    end else if (rep_fire) begin
      push_ev.code      = MAX_KEY_W'(rep_key);
      push_ev.press     = 1'b1;
      push_ev.is_repeat = 1'b1;
    end
  end
`else
  assign push = toggle;

  always_comb begin
    push_ev       = '0;
    push_ev.code  = MAX_KEY_W'(key_idx);
    push_ev.press = key_now;
  end
`endif

  logic [EV_W-1:0] head_bits;
  key_event_t      head_ev;
  logic            fifo_empty;
  logic            fifo_drop;
  logic            unused_fifo_full;
  logic            unused_head;

  keypad_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clock_keyboards (clock_keyboards),
    .reset_n         (reset_n),
    .push            (push),
    .push_data       (push_ev),
    .pop             (event_ready),
    .head            (head_bits),
    .empty           (fifo_empty),
    .full            (unused_fifo_full),
    .drop            (fifo_drop)
  );

  assign head_ev     = key_event_t'(head_bits);
  assign unused_head = ^head_bits;
  assign event_valid = !fifo_empty;
  assign event_code  = fifo_empty ? '0 : head_ev.code[KEY_W-1:0];
  assign event_press = !fifo_empty && head_ev.press;
`ifdef KEYPAD_REPEAT_EN
  assign event_repeat = !fifo_empty && head_ev.is_repeat;
`else
  assign event_repeat = 1'b0;
`endif

  // A drop in the same cycle as a clear wins, so no lost event goes unreported.
  always_ff @(posedge clock_keyboards or negedge reset_n) begin
    if (!reset_n)            overflow <= 1'b0;
    else if (fifo_drop)      overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

endmodule
